// File: rtl/mic_array_cmd_scheduler_pkg.sv
// mic_sched_pkg
//   Shared types and constants for the mic_array command scheduler.
//   - mic_sched_state_t : scheduler FSM state encoding
//   - ch_width()        : channel-index width for a given channel count
//   - CH_DATA_RST_BIT   : fill bit for the ch_data reset value
package mic_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREWAIT,
      S_START,
      S_ACK,
      S_RUN,
      S_NEXT,
      S_DONE
   } mic_sched_state_t;

   // A single-channel build still needs a 1-bit index.
   localparam int CH_W_MIN = 1;

   localparam logic CH_DATA_RST_BIT = 1'b0;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : CH_W_MIN;
   endfunction

endpackage

// File: rtl/mic_array_cmd_scheduler_timer.sv
// mic_sched_timer
//   Wait-phase watchdog for the mic_array command scheduler. Loadable
//   down-counter: 'load' arms it so that 'expired' rises in the
//   TIMEOUT_CYC-th consecutive cycle with 'en' high. 'expired' is a
//   single-cycle indication because the owner leaves its wait state on it.
//   Only instantiated when MIC_SCHED_TIMEOUT_EN is defined.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : reload the counter (on entry to a wait state)
//   en         : count this cycle (owner is in a wait state)
//   expired    : wait budget exhausted in the current cycle
module mic_sched_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   // The entry cycle already counts as the first waited cycle.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/mic_array_cmd_scheduler.sv
// mic_array_cmd_scheduler
//   Dispatches host configuration commands to N_CH mic_array serial-control
//   channels, one channel at a time: waits for the channel to be idle,
//   pulses its start line, then follows its busy handshake to completion.
//   Unicast goes to cmd_channel; broadcast walks channels 0..N_CH-1.
//   Optional feature macro: MIC_SCHED_TIMEOUT_EN adds a per-wait-state
//   watchdog (TIMEOUT_CYC cycles) with sticky per-channel timeout flags;
//   without it wait states block indefinitely and err_timeout reads 0.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready   : host command handshake (ready only in IDLE)
//   cmd_channel       : unicast target channel
//   cmd_broadcast     : walk all channels in order
//   cmd_data          : command word
//   ch_start          : one-hot single-cycle start pulse
//   ch_data           : command word latched at accept
//   ch_busy           : per-channel busy handshake
//   sched_busy        : scheduler not IDLE
//   done_pulse        : one cycle at the end of every command
//   err_timeout       : sticky per-channel timeout flags
//   err_range         : sticky out-of-range unicast flag
//   err_clear         : clear sticky flags (a simultaneous set wins)
module mic_array_cmd_scheduler
   import mic_sched_pkg::*;
#(
   parameter int N_CH        = 16,
   parameter int CH_W        = ch_width(N_CH),
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_channel,
   input  logic              cmd_broadcast,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [N_CH-1:0]   ch_start,
   output logic [DATA_W-1:0] ch_data,
   input  logic [N_CH-1:0]   ch_busy,
   output logic              sched_busy,
   output logic              done_pulse,
   output logic [N_CH-1:0]   err_timeout,
   output logic              err_range,
   input  logic              err_clear
);

   mic_sched_state_t state, state_next;

   logic [CH_W-1:0] idx;
   logic            bcast;
   logic [N_CH-1:0] sel;
   logic            busy_sel;
   logic            accept;
   logic            range_bad;
   logic            last_ch;
   logic            wait_met;
   logic            timeout;

   assign accept    = cmd_valid && (state == S_IDLE);
   assign range_bad = !cmd_broadcast && (int'(cmd_channel) >= N_CH);
   assign last_ch   = !bcast || (int'(idx) >= N_CH - 1);

   // One-hot decode of the active channel; an index beyond N_CH selects
   // nothing, so ch_busy is never indexed out of range.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         sel[i] = (int'(idx) == i);
      end
   end

   assign busy_sel = |(ch_busy & sel);

   // Condition that ends the current wait state normally.
   always_comb begin
      wait_met = 1'b0;
      case (state)
         S_PREWAIT: wait_met = !busy_sel;
         S_ACK:     wait_met = busy_sel;
         S_RUN:     wait_met = !busy_sel;
         default:   wait_met = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A normal exit takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      sched_busy = 1'b1;
      done_pulse = 1'b0;
      ch_start   = '0;
      case (state)
         S_IDLE: begin
            cmd_ready  = 1'b1;
            sched_busy = 1'b0;
            if (accept) begin
               state_next = range_bad ? S_DONE : S_PREWAIT;
            end
         end
         S_PREWAIT: begin
            if (wait_met)     state_next = S_START;
            else if (timeout) state_next = S_NEXT;
         end
         S_START: begin
            ch_start   = sel;
            state_next = S_ACK;
         end
         S_ACK: begin
            if (wait_met)     state_next = S_RUN;
            else if (timeout) state_next = S_NEXT;
         end
         S_RUN: begin
            if (wait_met || timeout) state_next = S_NEXT;
         end
         S_NEXT: begin
            state_next = last_ch ? S_DONE : S_PREWAIT;
         end
         S_DONE: begin
            done_pulse = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         bcast   <= 1'b0;
         ch_data <= {DATA_W{CH_DATA_RST_BIT}};
      end else if (accept) begin
         idx     <= cmd_broadcast ? '0 : cmd_channel;
         bcast   <= cmd_broadcast;
         ch_data <= cmd_data;
      end else if ((state == S_NEXT) && !last_ch) begin
         idx <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_range <= 1'b0;
      end else if (accept && range_bad) begin
         err_range <= 1'b1;
      end else if (err_clear) begin
         err_range <= 1'b0;
      end
   end

`ifdef MIC_SCHED_TIMEOUT_EN
   logic            wait_state;
   logic            timer_load;
   logic [N_CH-1:0] timeout_set;
   logic [N_CH-1:0] tmo_flags;

   assign wait_state = (state == S_PREWAIT) || (state == S_ACK) || (state == S_RUN);

   // Reload on every entry into a wait state, including ACK->RUN.
   assign timer_load = (state_next != state) &&
                       ((state_next == S_PREWAIT) || (state_next == S_ACK) ||
                        (state_next == S_RUN));

   mic_sched_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (timer_load),
      .en      (wait_state),
      .expired (timeout)
   );

   assign timeout_set = (timeout && wait_state && !wait_met) ? sel : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_flags <= '0;
      end else begin
         tmo_flags <= (err_clear ? '0 : tmo_flags) | timeout_set;
      end
   end

   assign err_timeout = tmo_flags;
`else
   assign timeout     = 1'b0;
   assign err_timeout = '0;
`endif

endmodule

// File: doc/mic_array_cmd_scheduler.md
# mic_array_cmd_scheduler

Dispatches host configuration commands to the N_CH mic_array serial-control channels of the SoM fabric, one channel at a time. Issues a start pulse with the command word, then tracks each channel's busy handshake to completion. Unicast and broadcast (walk all channels) are supported. Sits between the HPS-facing command register bridge and the per-array control ports (`micarrayK_control_busy_out` / serial engine).

## Interface
- `N_CH`, 16, number of mic_array channels (1..16)
- `CH_W`, 4, channel index width, `$clog2(N_CH)` minimum 1
- `DATA_W`, 32, command word width
- `TIMEOUT_CYC`, 4096, max cycles allowed in any wait phase (≥2)

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: scheduler can accept.
- `cmd_channel` in CH_W: target channel for unicast.
- `cmd_broadcast` in 1: 1 means send to channels 0..N_CH-1 in order.
- `cmd_data` in DATA_W: command word.
- `ch_start` out N_CH: one-hot, single-cycle start pulse.
- `ch_data` out DATA_W: latched command word, stable for the whole command.
- `ch_busy` in N_CH: per-channel busy, synchronous to clk.
- `sched_busy` out 1: high in every state except IDLE.
- `done_pulse` out 1: one cycle at the end of a command, including a broadcast.
- `err_timeout` out N_CH: sticky per-channel timeout flags.
- `err_range` out 1: sticky flag for an out-of-range unicast channel.
- `err_clear` in 1: clears all sticky flags.

## Operation
- Accept: `cmd_valid & cmd_ready`. `cmd_ready` equals (state==IDLE). On accept, latch channel, data and broadcast, and set idx = broadcast ? 0 : channel.
- States:
  - IDLE
  - PREWAIT: wait for `ch_busy[idx]` to be 0.
  - START: `ch_start[idx]`=1 for one cycle.
  - ACK: wait for `ch_busy[idx]` to be 1.
  - RUN: wait for `ch_busy[idx]` to be 0.
  - NEXT
  - DONE: `done_pulse`=1.
- Transitions:
  - IDLE→PREWAIT on accept.
  - PREWAIT→START when busy is low. This is checked in the first PREWAIT cycle.
  - START→ACK unconditionally.
  - ACK→RUN when busy is high.
  - RUN→NEXT when busy is low.
  - NEXT→PREWAIT with idx+1 if broadcast and idx<N_CH-1; otherwise NEXT→DONE.
  - DONE→IDLE.
- Unicast with channel ≥ N_CH: IDLE→DONE directly. Set `err_range`. No start pulse is issued.
- Timeout: the wait timer reloads on entry to PREWAIT, ACK or RUN. If it expires, set `err_timeout[idx]` and go to NEXT. On a broadcast, the remaining channels are still serviced.
- Sticky flags: if a set and `err_clear` occur in the same cycle, the set wins.
- `ch_data` updates only on accept and holds between commands.
- Reset values:
  - `cmd_ready`=1 after reset deasserts.
  - `ch_start`=0, `ch_data`=0, `sched_busy`=0, `done_pulse`=0, `err_timeout`=0, `err_range`=0.
  - State IDLE.
- Reset mid-operation aborts the command. No further start pulse is issued and no `done_pulse` is produced.

## Timing
- Accept at edge T. PREWAIT during T+1. If the channel is idle, `ch_start` is high during cycle T+2.
- A busy rise seen in cycle T+3 moves to RUN at T+4.
- After busy falls, NEXT takes 1 cycle, then DONE/`done_pulse` takes 1 cycle. `cmd_ready` rises the cycle after `done_pulse`.
- Per-channel overhead excluding the busy interval: 4 cycles (PREWAIT, START, ACK, NEXT).
- A busy pulse of 1 cycle seen in ACK is legal. The FSM goes to RUN, then NEXT on the next low cycle.
- Timeout fires after exactly TIMEOUT_CYC cycles in one wait state. For example, with TIMEOUT_CYC=4096 and no ack, ACK lasts 4096 cycles, then NEXT.

## Configuration
- `MIC_SCHED_TIMEOUT_EN` defined: the timer is instantiated and the timeout behaviour above applies.
- Not defined: no timer is instantiated. Wait states block indefinitely. `err_timeout` is tied to 0. `TIMEOUT_CYC` is ignored.

## Structure
- `mic_sched_pkg`:
  - state enum `mic_sched_state_t`
  - localparam helpers for CH_W
  - reset constants for `ch_data`
- Sub-module `mic_sched_timer`:
  - loadable down-counter sized `$clog2(TIMEOUT_CYC+1)`
  - inputs: `load`, `en`
  - output: single-cycle `expired`
  - instantiated only under `MIC_SCHED_TIMEOUT_EN`

## Test plan
- Unicast: cmd ch=5, data=0xA5A5_0001. The ch5 model raises busy 2 cycles after start and holds it for 10 cycles. Expect `ch_start`=0x0020 for 1 cycle at T+2, `ch_data`=0xA5A50001, one `done_pulse`, and `cmd_ready` back high.
- Broadcast with all models ack'ing: expect 16 start pulses in order 0..15, one per channel, each only after the previous busy falls, then exactly one `done_pulse`.
- PREWAIT: ch3 is busy at accept and stays high for 20 cycles. Expect no start until ch3 busy falls, then start on the following cycle.
- Timeout (macro on, TIMEOUT_CYC=16): broadcast with ch7 never ack'ing. Expect `err_timeout`=0x0080, channels 8..15 still started, and `done_pulse`. Then `err_clear` returns the flags to 0.
- Range and reset: with N_CH=12, unicast ch=13 gives `err_range`=1, no start, and `done_pulse` at T+1. Asserting reset during RUN forces all outputs to reset values, and no `done_pulse` follows.
